// File: rtl/msi_pkg.sv
// Shared types and defaults for the cache MSI request path: queue entry layout
// and the round-robin pointer increment used by the request arbiter.
package msi_pkg;

    localparam int unsigned MSI_NUM_REQ    = 4;
    localparam int unsigned MSI_DATA_WIDTH = 32;
    localparam int unsigned MSI_ID_WIDTH   = $clog2(MSI_NUM_REQ);

    // Default-configuration queue entry; packed so the id sits above the payload.
    typedef struct packed {
        logic [MSI_ID_WIDTH-1:0]   id;
        logic [MSI_DATA_WIDTH-1:0] data;
    } msi_entry_t;

    // Explicit wrap so requester counts that are not a power of two behave.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned num);
        return (idx == num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with optional fall-through, flush and fill-level output.
// usage_o wraps to 0 when the FIFO holds DEPTH entries.
module fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    dtype                  r_mem [DEPTH];
    logic [ADDR_DEPTH-1:0] r_rd_ptr;
    logic [ADDR_DEPTH-1:0] r_wr_ptr;
    logic [ADDR_DEPTH:0]   r_cnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_unused_testmode;

    assign w_unused_testmode = testmode_i;

    assign full_o   = (r_cnt == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o  = (r_cnt == '0) & ~(FALL_THROUGH & push_i);
    assign usage_o  = r_cnt[ADDR_DEPTH-1:0];

    // A fall-through push into an empty FIFO that is popped the same cycle never lands in storage.
    assign w_bypass = FALL_THROUGH & (r_cnt == '0) & push_i;
    assign data_o   = w_bypass ? data_i : r_mem[r_rd_ptr];
    assign w_push   = push_i & ~full_o & ~(w_bypass & pop_i);
    assign w_pop    = pop_i & ~empty_o & ~w_bypass;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/msg_queue_arbiter.sv
// Round-robin arbiter sharing one request queue among NUM_REQ requesters;
// each entry is tagged with its source id and drained over valid/ready.
module msg_queue_arbiter
    import msi_pkg::*;
#(
    parameter int unsigned NUM_REQ    = MSI_NUM_REQ,
    parameter int unsigned DATA_WIDTH = MSI_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ),
    parameter int unsigned ADDR_DEPTH = $clog2(DEPTH)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               testmode_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [DATA_WIDTH-1:0]              out_data_o,
    output logic [ID_WIDTH-1:0]                out_id_o,
    output logic [ADDR_DEPTH-1:0]              usage_o,
    output logic                               full_o
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam int unsigned WAIT_W = $clog2(NUM_REQ + 1);
    localparam int          NUM_I  = int'(NUM_REQ);

    logic [ID_WIDTH-1:0] r_rr_q;
    logic [ID_WIDTH-1:0] w_winner;
    logic                w_any_valid;
    logic                w_grant_en;
    logic                w_empty;
    logic                w_pop;
    entry_t              w_push_entry;
    entry_t              w_head;
    logic [WAIT_W-1:0]   r_wait_cnt [NUM_REQ];

    // First valid index at or after rr, wrapping modulo NUM_REQ; lowest offset wins.
    function automatic logic [ID_WIDTH-1:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                                        input logic [ID_WIDTH-1:0] rr);
        logic [ID_WIDTH-1:0] win;
        int                  idx;
        win = rr;
        for (int k = NUM_I - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= NUM_I) begin
                idx = idx - NUM_I;
            end
            if (valid[idx]) begin
                win = ID_WIDTH'(idx);
            end
        end
        return win;
    endfunction

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    // Ready on the request side depends on valid, so requesters must not wait for
    // ready before raising valid. Nothing is accepted while rst_ni is low.
    assign w_any_valid = |req_valid_i;
    assign w_winner    = pick_winner(req_valid_i, r_rr_q);
    assign w_grant_en  = w_any_valid & ~full_o & ~flush_i & rst_ni;

    always_comb begin
        req_ready_o = '0;
        if (w_grant_en) begin
            req_ready_o[w_winner] = 1'b1;
        end
    end

    assign w_push_entry.id   = w_winner;
    assign w_push_entry.data = req_data_i[w_winner];

    assign out_valid_o = ~w_empty & ~flush_i;
    assign w_pop       = out_valid_o & out_ready_i;
    assign out_data_o  = w_head.data;
    assign out_id_o    = w_head.id;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_q <= '0;
        end else if (flush_i) begin
            r_rr_q <= '0;
        end else if (w_grant_en) begin
            r_rr_q <= ID_WIDTH'(rr_wrap_inc(32'(w_winner), NUM_REQ));
        end
    end

    fifo #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (ID_WIDTH + DATA_WIDTH),
        .DEPTH        (DEPTH),
        .dtype        (entry_t)
    ) i_req_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .testmode_i (testmode_i),
        .full_o     (full_o),
        .empty_o    (w_empty),
        .usage_o    (usage_o),
        .data_i     (w_push_entry),
        .push_i     (w_grant_en),
        .data_o     (w_head),
        .pop_i      (w_pop)
    );

    // Grants given to others while a requester keeps valid high and is passed over.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_I; i++) begin
                r_wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_I; i++) begin
                if (flush_i || !req_valid_i[i] || req_ready_o[i]) begin
                    r_wait_cnt[i] <= '0;
                end else if (w_grant_en) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));

    a_no_grant_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        full_o |-> (req_ready_o == '0));

    for (genvar g = 0; g < NUM_I; g++) begin : g_starve
        a_starvation: assert property (@(posedge clk_i) disable iff (!rst_ni)
            int'(r_wait_cnt[g]) < NUM_I);
    end

endmodule

// File: tb/tb_msg_queue_arbiter.sv
// Directed bench for msg_queue_arbiter: a 4-requester/depth-8 instance and a
// 3-requester/depth-4 instance exercising wrap-around of the priority pointer.
module tb_msg_queue_arbiter;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             testmode;

    logic [3:0]       v4;
    logic [3:0][31:0] d4;
    logic [3:0]       rdy4;
    logic             ov4;
    logic             or4;
    logic [31:0]      od4;
    logic [1:0]       oid4;
    logic [2:0]       use4;
    logic             full4;

    logic [2:0]       v3;
    logic [2:0][31:0] d3;
    logic [2:0]       rdy3;
    logic             ov3;
    logic             or3;
    logic [31:0]      od3;
    logic [1:0]       oid3;
    logic [1:0]       use3;
    logic             full3;

    int tests_run;
    int tests_failed;

    msg_queue_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .DEPTH(8)) dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .testmode_i  (testmode),
        .req_valid_i (v4),
        .req_data_i  (d4),
        .req_ready_o (rdy4),
        .out_valid_o (ov4),
        .out_ready_i (or4),
        .out_data_o  (od4),
        .out_id_o    (oid4),
        .usage_o     (use4),
        .full_o      (full4)
    );

    msg_queue_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .DEPTH(4)) dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .testmode_i  (testmode),
        .req_valid_i (v3),
        .req_data_i  (d3),
        .req_ready_o (rdy3),
        .out_valid_o (ov3),
        .out_ready_i (or3),
        .out_data_o  (od3),
        .out_id_o    (oid3),
        .usage_o     (use3),
        .full_o      (full3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; testmode = 1'b0;
        v4 = 4'hF; v3 = 3'h7; or4 = 1'b0; or3 = 1'b0;
        for (int i = 0; i < 4; i++) d4[i] = 32'hC0DE_0000 + i;
        for (int i = 0; i < 3; i++) d3[i] = 32'hBEEF_0000 + i;
        repeat (2) @(posedge clk);
        #2;
        tests_run++; if (rdy4 !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready4 got=%b exp=0000", rdy4); end
        tests_run++; if (rdy3 !== 3'b000) begin tests_failed++; $display("FAIL reset_ready3 got=%b exp=000", rdy3); end
        tests_run++; if (ov4 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", ov4); end
        tests_run++; if (use4 !== 3'd0) begin tests_failed++; $display("FAIL reset_usage got=%0d exp=0", use4); end
        tests_run++; if (full4 !== 1'b0) begin tests_failed++; $display("FAIL reset_full got=%b exp=0", full4); end
        tests_run++; if (dut4.r_rr_q !== 2'd0) begin tests_failed++; $display("FAIL reset_rr got=%0d exp=0", dut4.r_rr_q); end
        v4 = 4'h0; v3 = 3'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_r;
        int         e;
        v4 = 4'hF; or4 = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            exp_r = 4'b0001 << (c % 4);
            tests_run++; if (rdy4 !== exp_r) begin tests_failed++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, rdy4, exp_r); end
            if (c == 0) begin
                tests_run++; if (ov4 !== 1'b0 || use4 !== 3'd0) begin tests_failed++; $display("FAIL rr_latency valid=%b usage=%0d exp valid=0 usage=0", ov4, use4); end
            end else begin
                e = (c - 1) % 4;
                tests_run++;
                if (ov4 !== 1'b1 || oid4 !== 2'(e) || od4 !== 32'hC0DE_0000 + e || use4 !== 3'd1) begin
                    tests_failed++;
                    $display("FAIL rr_head c=%0d valid=%b id=%0d data=%h usage=%0d exp 1/%0d/%h/1", c, ov4, oid4, od4, use4, e, 32'hC0DE_0000 + e);
                end
            end
            @(posedge clk); #1;
            if (c == 7) v4 = 4'h0;
            #1;
        end
        tests_run++; if (ov4 !== 1'b1 || oid4 !== 2'd3 || od4 !== 32'hC0DE_0003) begin tests_failed++; $display("FAIL rr_last valid=%b id=%0d data=%h exp 1/3/c0de0003", ov4, oid4, od4); end
        @(posedge clk); #2;
        tests_run++; if (ov4 !== 1'b0 || use4 !== 3'd0) begin tests_failed++; $display("FAIL rr_drain valid=%b usage=%0d exp 0/0", ov4, use4); end
        tests_run++; if (dut4.r_rr_q !== 2'd0) begin tests_failed++; $display("FAIL rr_ptr_end got=%0d exp=0", dut4.r_rr_q); end
        or4 = 1'b0;
    endtask

    task automatic test_single_full();
        v4 = 4'b0100; or4 = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            tests_run++;
            if (rdy4 !== 4'b0100 || use4 !== 3'(c) || full4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_grant c=%0d ready=%b usage=%0d full=%b exp 0100/%0d/0", c, rdy4, use4, full4, c);
            end
            tests_run++;
            if (dut4.r_rr_q !== ((c == 0) ? 2'd0 : 2'd3)) begin
                tests_failed++;
                $display("FAIL single_rr c=%0d got=%0d exp=%0d", c, dut4.r_rr_q, (c == 0) ? 0 : 3);
            end
            @(posedge clk); #2;
        end
        tests_run++; if (full4 !== 1'b1 || rdy4 !== 4'b0000 || use4 !== 3'd0) begin tests_failed++; $display("FAIL single_full full=%b ready=%b usage=%0d exp 1/0000/0", full4, rdy4, use4); end
        tests_run++; if (ov4 !== 1'b1 || oid4 !== 2'd2 || od4 !== 32'hC0DE_0002) begin tests_failed++; $display("FAIL single_head valid=%b id=%0d data=%h exp 1/2/c0de0002", ov4, oid4, od4); end
        tests_run++; if (dut4.r_rr_q !== 2'd3) begin tests_failed++; $display("FAIL single_rr_end got=%0d exp=3", dut4.r_rr_q); end
    endtask

    task automatic test_full_pop();
        v4 = 4'hF; or4 = 1'b1;
        #1;
        tests_run++; if (rdy4 !== 4'b0000 || ov4 !== 1'b1) begin tests_failed++; $display("FAIL fullpop_same ready=%b valid=%b exp 0000/1", rdy4, ov4); end
        @(posedge clk); #1;
        or4 = 1'b0;
        #1;
        tests_run++; if (use4 !== 3'd7 || full4 !== 1'b0 || rdy4 !== 4'b1000) begin tests_failed++; $display("FAIL fullpop_next usage=%0d full=%b ready=%b exp 7/0/1000", use4, full4, rdy4); end
        tests_run++; if (oid4 !== 2'd2) begin tests_failed++; $display("FAIL fullpop_head id=%0d exp=2", oid4); end
        @(posedge clk); #1;
        v4 = 4'h0;
        #1;
        tests_run++; if (full4 !== 1'b1 || use4 !== 3'd0 || rdy4 !== 4'b0000) begin tests_failed++; $display("FAIL fullpop_refill full=%b usage=%0d ready=%b exp 1/0/0000", full4, use4, rdy4); end
        tests_run++; if (dut4.r_rr_q !== 2'd0) begin tests_failed++; $display("FAIL fullpop_rr got=%0d exp=0", dut4.r_rr_q); end
    endtask

    task automatic test_flush();
        flush = 1'b1; v4 = 4'b0001;
        #1;
        tests_run++; if (rdy4 !== 4'b0000 || ov4 !== 1'b0) begin tests_failed++; $display("FAIL flush_full_same ready=%b valid=%b exp 0000/0", rdy4, ov4); end
        @(posedge clk); #1;
        flush = 1'b0; v4 = 4'h0;
        #1;
        tests_run++; if (use4 !== 3'd0 || full4 !== 1'b0 || ov4 !== 1'b0 || dut4.r_rr_q !== 2'd0) begin tests_failed++; $display("FAIL flush_full_after usage=%0d full=%b valid=%b rr=%0d exp 0/0/0/0", use4, full4, ov4, dut4.r_rr_q); end
        v4 = 4'b0010;
        #1;
        for (int c = 0; c < 5; c++) begin
            tests_run++; if (rdy4 !== 4'b0010) begin tests_failed++; $display("FAIL flush_fill c=%0d ready=%b exp=0010", c, rdy4); end
            @(posedge clk); #2;
        end
        flush = 1'b1; v4 = 4'b1010;
        #1;
        tests_run++; if (use4 !== 3'd5 || dut4.r_rr_q !== 2'd2) begin tests_failed++; $display("FAIL flush_pre usage=%0d rr=%0d exp 5/2", use4, dut4.r_rr_q); end
        tests_run++; if (rdy4 !== 4'b0000 || ov4 !== 1'b0) begin tests_failed++; $display("FAIL flush_same ready=%b valid=%b exp 0000/0", rdy4, ov4); end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        tests_run++; if (use4 !== 3'd0 || ov4 !== 1'b0 || dut4.r_rr_q !== 2'd0) begin tests_failed++; $display("FAIL flush_next usage=%0d valid=%b rr=%0d exp 0/0/0", use4, ov4, dut4.r_rr_q); end
        tests_run++; if (rdy4 !== 4'b0010) begin tests_failed++; $display("FAIL flush_regrant ready=%b exp=0010", rdy4); end
        @(posedge clk); #1;
        v4 = 4'h0;
        #1;
        tests_run++; if (use4 !== 3'd1 || ov4 !== 1'b1 || oid4 !== 2'd1 || od4 !== 32'hC0DE_0001) begin tests_failed++; $display("FAIL flush_head usage=%0d valid=%b id=%0d data=%h exp 1/1/1/c0de0001", use4, ov4, oid4, od4); end
        tests_run++; if (dut4.r_rr_q !== 2'd2) begin tests_failed++; $display("FAIL flush_rr_after got=%0d exp=2", dut4.r_rr_q); end
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        #1;
        tests_run++; if (ov4 !== 1'b0) begin tests_failed++; $display("FAIL flush_drain valid=%b exp=0", ov4); end
    endtask

    task automatic test_wrap3();
        v3 = 3'b010; or3 = 1'b1;
        #1;
        tests_run++; if (rdy3 !== 3'b010) begin tests_failed++; $display("FAIL wrap3_setup ready=%b exp=010", rdy3); end
        @(posedge clk); #1;
        v3 = 3'b101;
        #1;
        tests_run++; if (dut3.r_rr_q !== 2'd2 || rdy3 !== 3'b100) begin tests_failed++; $display("FAIL wrap3_first rr=%0d ready=%b exp 2/100", dut3.r_rr_q, rdy3); end
        tests_run++; if (ov3 !== 1'b1 || oid3 !== 2'd1) begin tests_failed++; $display("FAIL wrap3_head1 valid=%b id=%0d exp 1/1", ov3, oid3); end
        @(posedge clk); #2;
        tests_run++; if (dut3.r_rr_q !== 2'd0 || rdy3 !== 3'b001) begin tests_failed++; $display("FAIL wrap3_second rr=%0d ready=%b exp 0/001", dut3.r_rr_q, rdy3); end
        tests_run++; if (ov3 !== 1'b1 || oid3 !== 2'd2 || od3 !== 32'hBEEF_0002) begin tests_failed++; $display("FAIL wrap3_head2 valid=%b id=%0d data=%h exp 1/2/beef0002", ov3, oid3, od3); end
        @(posedge clk); #1;
        v3 = 3'b000;
        #1;
        tests_run++; if (dut3.r_rr_q !== 2'd1 || ov3 !== 1'b1 || oid3 !== 2'd0 || od3 !== 32'hBEEF_0000) begin tests_failed++; $display("FAIL wrap3_head0 rr=%0d valid=%b id=%0d data=%h exp 1/1/0/beef0000", dut3.r_rr_q, ov3, oid3, od3); end
        @(posedge clk); #2;
        tests_run++; if (ov3 !== 1'b0 || use3 !== 2'd0 || full3 !== 1'b0) begin tests_failed++; $display("FAIL wrap3_drain valid=%b usage=%0d full=%b exp 0/0/0", ov3, use3, full3); end
        or3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        or4 = 1'b0; v4 = 4'b1100;
        #1;
        tests_run++; if (rdy4 !== 4'b0100) begin tests_failed++; $display("FAIL mid_first ready=%b exp=0100", rdy4); end
        @(posedge clk); #2;
        tests_run++; if (rdy4 !== 4'b1000 || use4 !== 3'd1) begin tests_failed++; $display("FAIL mid_second ready=%b usage=%0d exp 1000/1", rdy4, use4); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (ov4 !== 1'b0 || use4 !== 3'd0 || full4 !== 1'b0 || rdy4 !== 4'b0000) begin tests_failed++; $display("FAIL mid_async valid=%b usage=%0d full=%b ready=%b exp 0/0/0/0000", ov4, use4, full4, rdy4); end
        tests_run++; if (dut4.r_rr_q !== 2'd0) begin tests_failed++; $display("FAIL mid_async_rr got=%0d exp=0", dut4.r_rr_q); end
        @(posedge clk); #2;
        tests_run++; if (rdy4 !== 4'b0000 || use4 !== 3'd0) begin tests_failed++; $display("FAIL mid_held ready=%b usage=%0d exp 0000/0", rdy4, use4); end
        rst_n = 1'b1;
        #1;
        tests_run++; if (rdy4 !== 4'b0100 || ov4 !== 1'b0) begin tests_failed++; $display("FAIL mid_release ready=%b valid=%b exp 0100/0", rdy4, ov4); end
        @(posedge clk); #1;
        v4 = 4'h0;
        #1;
        tests_run++; if (ov4 !== 1'b1 || oid4 !== 2'd2 || use4 !== 3'd1) begin tests_failed++; $display("FAIL mid_after valid=%b id=%0d usage=%0d exp 1/2/1", ov4, oid4, use4); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_round_robin();
        test_single_full();
        test_full_pop();
        test_flush();
        test_wrap3();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        tests_failed++;
        $display("FAIL watchdog time=%0t limit=100000", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
